dom_and_sched: RTL and testbench

DOM_AND_SCHED -- requirements
Module: dom_and_sched

---
 rtl/dom_and_sched.sv | 116 +++++++++++
 tb/tb_dom_and_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dom_and_sched.sv
// dom_and_sched: round-robin scheduler feeding one shared 2-share DOM-AND gadget.
// The gadget's randomness comes from a 16-bit Fibonacci LFSR that advances only on issue.
`default_nettype none

module dom_and_sched #(
  parameter int          NREQ = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_a0,
  input  logic [NREQ-1:0]          req_a1,
  input  logic [NREQ-1:0]          req_b0,
  input  logic [NREQ-1:0]          req_b1,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_c0,
  output logic                     rsp_c1,
  input  logic                     seed_valid,
  input  logic [15:0]              seed
);

  localparam int                IDW    = $clog2(NREQ);
  localparam int                IDW1   = IDW + 1;
  localparam logic [IDW:0]      C_NREQ = IDW1'(NREQ);
  localparam logic [IDW-1:0]    C_LAST = IDW'(NREQ - 1);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic           r_valid;
  logic [15:0]    r_lfsr;
  logic           r_a0b0, r_a1b1, r_a0b1z, r_a1b0z;

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_win;
  logic           w_any;
  logic           w_slot_free;
  logic           w_issue;
  logic           w_a0, w_a1, w_b0, w_b1, w_z;
  logic [15:0]    w_lfsr_next;

  // Round-robin search starting at r_ptr; first requesting index wins.
  always_comb begin
    w_sum = '0;
    w_idx = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + IDW1'(k);
      w_idx = (w_sum >= C_NREQ) ? IDW'(w_sum - C_NREQ) : IDW'(w_sum);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_slot_free = !r_valid || rsp_ready;
  assign w_issue     = w_slot_free && w_any;

  // Grant is gated by rst_n so req_ready reads 0 for the whole reset window.
  always_comb begin
    req_ready = '0;
    if (rst_n && w_issue) req_ready[w_win] = 1'b1;
  end

  assign w_a0        = req_a0[w_win];
  assign w_a1        = req_a1[w_win];
  assign w_b0        = req_b0[w_win];
  assign w_b1        = req_b1[w_win];
  assign w_z         = r_lfsr[0];
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_lfsr  <= SEED;
      r_a0b0  <= 1'b0;
      r_a1b1  <= 1'b0;
      r_a0b1z <= 1'b0;
      r_a1b0z <= 1'b0;
    end else begin
      if (w_issue) begin
        r_ptr   <= (w_win == C_LAST) ? '0 : w_win + 1'b1;
        r_id    <= w_win;
        r_valid <= 1'b1;
        r_a0b0  <= w_a0 & w_b0;
        r_a1b1  <= w_a1 & w_b1;
        r_a0b1z <= (w_a0 & w_b1) ^ w_z;
        r_a1b0z <= (w_a1 & w_b0) ^ w_z;
      end else if (rsp_ready) begin
        r_valid <= 1'b0;
      end
      // A nonzero reseed wins over the issue-driven advance.
      if (seed_valid && (seed != 16'h0000)) begin
        r_lfsr <= seed;
      end else if (w_issue) begin
        r_lfsr <= w_lfsr_next;
      end
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_c0    = r_a1b1 ^ r_a1b0z;
  assign rsp_c1    = r_a0b0 ^ r_a0b1z;

endmodule

`default_nettype wire

// File: tb/tb_dom_and_sched.sv
// tb_dom_and_sched: directed and randomised stimulus checked every cycle against a
// behavioural scheduler/gadget model, plus hand-computed literal expectations.
`default_nettype none

module tb_dom_and_sched;

  localparam int NREQ = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid, req_ready, req_a0, req_a1, req_b0, req_b1;
  logic            rsp_valid, rsp_ready, rsp_c0, rsp_c1, seed_valid;
  logic [1:0]      rsp_id;
  logic [15:0]     seed;

  int n_checks = 0;
  int n_err    = 0;

  dom_and_sched #(.NREQ(NREQ), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c0(rsp_c0), .rsp_c1(rsp_c1),
    .seed_valid(seed_valid), .seed(seed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr   = 0;
  bit          m_valid = 0;
  int          m_id    = 0;
  bit          m_c0    = 0;
  bit          m_c1    = 0;
  logic [15:0] m_s     = SEED;

  function automatic int winner(input int ptr, input logic [NREQ-1:0] v);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int fb;
    fb = (s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10);
    return 16'((int'(s) << 1) | (fb & 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  w;
    bit  z, a0, a1, b0, b1, issue;
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_c0 = 0; m_c1 = 0; m_s = SEED;
    end else begin
      w     = winner(m_ptr, req_valid);
      issue = (!m_valid || rsp_ready) && (w >= 0);
      if (issue) begin
        z  = m_s[0];
        a0 = req_a0[w]; a1 = req_a1[w]; b0 = req_b0[w]; b1 = req_b1[w];
        // Shares follow the DOM-AND definition; their XOR must equal a&b.
        m_c0 = (a1 & b1) ^ (a1 & b0) ^ z;
        m_c1 = (a0 & b0) ^ (a0 & b1) ^ z;
        m_id = w;
        m_valid = 1;
        m_ptr = (w + 1) % NREQ;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      if (seed_valid && seed != 0) m_s = seed;
      else if (issue)              m_s = lfsr_step(m_s);
    end
  end

  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_rr;
    exp_rr = '0;
    w = winner(m_ptr, req_valid);
    if (rst_n && (!m_valid || rsp_ready) && w >= 0) exp_rr[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("rsp_c0",    32'(rsp_c0),    32'(m_c0));
    chk("rsp_c1",    32'(rsp_c1),    32'(m_c1));
    if (rsp_valid) begin
      n_checks++;
      if ((rsp_c0 ^ rsp_c1) !== ((m_c0 ^ m_c1))) begin
        n_err++;
        $display("FAIL recombine: got %0b expected %0b", rsp_c0 ^ rsp_c1, m_c0 ^ m_c1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic rand_ops(input int n);
    req_a0 = NREQ'($urandom); req_a1 = NREQ'($urandom);
    req_b0 = NREQ'($urandom); req_b1 = NREQ'($urandom);
    for (int i = 0; i < n; i++) begin
      req_a0 = NREQ'($urandom); req_a1 = NREQ'($urandom);
      req_b0 = NREQ'($urandom); req_b1 = NREQ'($urandom);
      cyc();
    end
  endtask

  initial begin
    logic [NREQ-1:0] e;
    logic [15:0]     s1;
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    seed_valid = 1'b0; seed = '0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    s1 = lfsr_step(SEED);
    chk("model_lfsr_step", 32'(s1), 32'h59C3);
    req_valid = '0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Single op: a=(1,0), b=(0,1) on requester 0, z = SEED[0] = 1
    req_valid = 4'b0001; req_a0 = 4'b0001; req_b1 = 4'b0001;
    #1 chk("single_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_id",    32'(rsp_id),    32'h0);
    chk("single_c0",    32'(rsp_c0),    32'h1);
    chk("single_c1",    32'(rsp_c1),    32'h0);
    cyc();

    // Round robin with all requesters active
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      #1 chk("rr_grant", 32'(req_ready), 32'(e));
      cyc();
      #1 chk("rr_id", 32'(rsp_id), 32'(k % 4));
    end

    // Backpressure: no grants while the result is held
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_grant", 32'(req_ready), 32'h2);
    cyc();
    #1 chk("bp_release_id", 32'(rsp_id), 32'h1);

    // Back-to-back issues, then issues with idle gaps
    rand_ops(20);
    for (int i = 0; i < 20; i++) begin
      req_valid = (i % 3 == 0) ? 4'h0 : NREQ'($urandom_range(1, 15));
      req_a0 = NREQ'($urandom); req_a1 = NREQ'($urandom);
      req_b0 = NREQ'($urandom); req_b1 = NREQ'($urandom);
      cyc();
    end

    // Reseed on an issue cycle: a0=0 makes c1 equal to z
    req_valid = 4'b0001; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = 4'hF;
    seed_valid = 1'b1; seed = 16'h0001;
    cyc();
    seed_valid = 1'b0;
    cyc();
    #1 chk("reseed_z1", 32'(rsp_c1), 32'h1);
    cyc();
    #1 chk("reseed_z2", 32'(rsp_c1), 32'h0);
    req_valid = '0; seed_valid = 1'b1; seed = 16'h0000;
    cyc();
    seed_valid = 1'b0; req_valid = 4'b0001;
    cyc();
    #1 chk("zero_seed_ignored", 32'(rsp_c1), 32'h0);

    // Reset with a held result: outputs clear without a clock edge
    req_valid = 4'b0001; req_a0 = 4'b0001; req_b0 = 4'b0001; req_b1 = '0;
    rsp_ready = 1'b0;
    cyc();
    req_valid = 4'hF;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mid_ready", 32'(req_ready), 32'h0);
    chk("rst_mid_id",    32'(rsp_id),    32'h0);
    chk("rst_mid_c0",    32'(rsp_c0),    32'h0);
    chk("rst_mid_c1",    32'(rsp_c1),    32'h0);
    cyc();
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = '0;
    cyc();

    // Random traffic, backpressure and occasional reseeds
    for (int i = 0; i < 80; i++) begin
      req_valid  = NREQ'($urandom);
      req_a0 = NREQ'($urandom); req_a1 = NREQ'($urandom);
      req_b0 = NREQ'($urandom); req_b1 = NREQ'($urandom);
      rsp_ready  = ($urandom % 4) != 0;
      seed_valid = ($urandom % 10) == 0;
      seed       = (($urandom % 3) == 0) ? 16'h0000 : 16'($urandom);
      cyc();
    end
    seed_valid = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
